// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: state encoding, default polynomial (x^8 + x^7 + 1) and one-step LFSR function.
// Pure declarations; no latency or flow-control behaviour of its own.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    localparam int PRBS_LFSR_W = 8;
    localparam int PRBS_TAP_A  = 7;
    localparam int PRBS_TAP_B  = 8;

    function automatic logic [PRBS_LFSR_W-1:0] prbs_next(input logic [PRBS_LFSR_W-1:0] sr);
        return {sr[PRBS_LFSR_W-2:0], sr[PRBS_TAP_A-1] ^ sr[PRBS_TAP_B-1]};
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// One LFSR step: predicted next bit and shifted register, shifting in either an external bit or the prediction.
// Purely combinational (zero latency); no backpressure.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int W     = PRBS_LFSR_W,
    parameter int TAP_A = PRBS_TAP_A,
    parameter int TAP_B = PRBS_TAP_B
) (
    input  logic [W-1:0] sr_i,
    input  logic         in_bit_i,
    input  logic         use_in_i,
    output logic         pred_o,
    output logic [W-1:0] sr_next_o
);

    assign pred_o    = sr_i[TAP_A-1] ^ sr_i[TAP_B-1];
    assign sr_next_o = {sr_i[W-2:0], (use_in_i ? in_bit_i : pred_o)};

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receive checker: seeds, hunts for lock, then counts bit errors with loss-of-lock detection.
// Errors reported 1 cycle after the sampling edge; in_valid=0 stalls all state (no backpressure output).
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LFSR_W   = PRBS_LFSR_W,
    parameter int TAP_A    = PRBS_TAP_A,
    parameter int TAP_B    = PRBS_TAP_B,
    parameter int LOCK_CNT = 16,
    parameter int LOL_WIN  = 64,
    parameter int LOL_ERRS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             rx_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_o
);

    localparam int FILL_W = $clog2(LFSR_W + 1);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(LOL_WIN + 1);
    localparam int WERR_W = $clog2(LOL_ERRS + 1);

    prbs_state_e       state_q, state_d;
    logic [LFSR_W-1:0] sr_q, sr_d, sr_step;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WERR_W-1:0] werr_q, werr_d, werr_inc;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              err_pulse_q, err_pulse_d;
    logic              pred, mismatch, use_rx;

    // Once locked the reference free-runs, so a line error cannot corrupt later predictions.
    assign use_rx = (state_q != ST_LOCKED);

    prbs_lfsr_step #(
        .W     (LFSR_W),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_step (
        .sr_i      (sr_q),
        .in_bit_i  (rx_bit),
        .use_in_i  (use_rx),
        .pred_o    (pred),
        .sr_next_o (sr_step)
    );

    assign mismatch = (rx_bit != pred);
    assign werr_inc = werr_q + WERR_W'(mismatch);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        run_d       = run_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;

        if (in_valid) begin
            sr_d = sr_step;
            if (clr_cnt) err_count_d = '0;
        end

        case (state_q)
            ST_SEED: begin
                if (in_valid) begin
                    if (fill_q == FILL_W'(LFSR_W - 1)) begin
                        state_d = ST_HUNT;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            ST_HUNT: begin
                if (in_valid) begin
                    // An all-zero register predicts zeros forever; never let it build a run.
                    if (mismatch || (sr_step == '0)) begin
                        run_d = '0;
                    end else if (run_q != RUN_W'(LOCK_CNT)) begin
                        run_d = run_q + 1'b1;
                    end
                    if ((run_d == RUN_W'(LOCK_CNT)) && (sr_step != '0)) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (in_valid) begin
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (!clr_cnt && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
                    end
                    if (werr_inc == WERR_W'(LOL_ERRS)) begin
                        state_d = ST_SEED;
                        fill_d  = '0;
                        run_d   = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WIN_W'(LOL_WIN - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_inc;
                    end
                end
            end
            default: begin
                state_d = ST_SEED;
                fill_d  = '0;
                run_d   = '0;
                win_d   = '0;
                werr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEED;
            sr_q        <= '0;
            fill_q      <= '0;
            run_q       <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock timing, error counting, loss of lock, stuck line, stalls, saturation and reset.
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, vld, rx, clr;
    logic        lk1, ep1, lk2, ep2;
    logic [15:0] ec1;
    logic [3:0]  ec2;
    logic [1:0]  st1, st2;
    logic [7:0]  g;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    prbs_checker u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .rx_bit(rx), .clr_cnt(clr),
        .locked(lk1), .err_pulse(ep1), .err_count(ec1), .state_o(st1)
    );

    prbs_checker #(.CNT_W(4), .LOL_ERRS(100)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .rx_bit(rx), .clr_cnt(clr),
        .locked(lk2), .err_pulse(ep2), .err_count(ec2), .state_o(st2)
    );

    // Reference generator, seed 8'h01: out = g[6]^g[7], shifted into g[0].
    task automatic gen(output logic b);
        b = g[6] ^ g[7];
        g = {g[6:0], b};
    endtask

    task automatic step(input logic v, input logic b);
        @(negedge clk);
        vld = v;
        rx  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            step(1'b1, b);
        end
    endtask

    task automatic feed_err(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            step(1'b1, ~b);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; vld = 1'b0; rx = 1'b0; clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        g = 8'h01;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vld = 1'b0; rx = 1'b0; clr = 1'b0; g = 8'h01;
        #2;
        checks++; if (lk1 !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", lk1); end
        checks++; if (ep1 !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", ep1); end
        checks++; if (ec1 !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ec1); end
        checks++; if (st1 !== ST_SEED) begin errors++; $display("FAIL reset_state: got %0d want 0", st1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock;
        int bad = 0;
        feed_clean(7);
        checks++; if (st1 !== ST_SEED) begin errors++; $display("FAIL seed_7: state %0d want 0", st1); end
        feed_clean(1);
        checks++; if (st1 !== ST_HUNT) begin errors++; $display("FAIL seed_8: state %0d want 1", st1); end
        feed_clean(15);
        checks++; if (lk1 !== 1'b0) begin errors++; $display("FAIL lock_23: locked %b want 0", lk1); end
        feed_clean(1);
        checks++; if (lk1 !== 1'b1 || st1 !== ST_LOCKED) begin
            errors++; $display("FAIL lock_24: locked %b state %0d want 1/2", lk1, st1);
        end
        for (int i = 0; i < 976; i++) begin
            feed_clean(1);
            if (ec1 !== 16'd0 || ep1 !== 1'b0 || lk1 !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clean_1000: %0d bad cycles want 0", bad); end
    endtask

    task automatic test_single_error;
        feed_err(1);
        checks++; if (ep1 !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b want 1", ep1); end
        checks++; if (ec1 !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", ec1); end
        checks++; if (lk1 !== 1'b1) begin errors++; $display("FAIL single_locked: got %b want 1", lk1); end
        step(1'b0, 1'b1);
        checks++; if (ep1 !== 1'b0 || ec1 !== 16'd1) begin
            errors++; $display("FAIL idle_hold: pulse %b count %0d want 0/1", ep1, ec1);
        end
        feed_clean(1);
        checks++; if (ep1 !== 1'b0 || ec1 !== 16'd1) begin
            errors++; $display("FAIL after_single: pulse %b count %0d want 0/1", ep1, ec1);
        end
    endtask

    task automatic test_async_reset;
        feed_err(1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (lk1 !== 1'b0 || ep1 !== 1'b0 || ec1 !== 16'd0 || st1 !== ST_SEED) begin
            errors++; $display("FAIL async_rst1: locked %b pulse %b count %0d state %0d want all 0", lk1, ep1, ec1, st1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        g = 8'h01;
    endtask

    task automatic test_lol_relock;
        do_reset();
        feed_clean(24);
        checks++; if (lk1 !== 1'b1) begin errors++; $display("FAIL lol_prelock: got %b want 1", lk1); end
        feed_err(7);
        checks++; if (lk1 !== 1'b1 || ec1 !== 16'd7) begin
            errors++; $display("FAIL lol_7err: locked %b count %0d want 1/7", lk1, ec1);
        end
        feed_err(1);
        checks++; if (lk1 !== 1'b0 || st1 !== ST_SEED || ep1 !== 1'b1 || ec1 !== 16'd8) begin
            errors++; $display("FAIL lol_8err: locked %b state %0d pulse %b count %0d want 0/0/1/8", lk1, st1, ep1, ec1);
        end
        feed_clean(23);
        checks++; if (lk1 !== 1'b0 || st1 !== ST_HUNT) begin
            errors++; $display("FAIL relock_23: locked %b state %0d want 0/1", lk1, st1);
        end
        feed_clean(1);
        checks++; if (lk1 !== 1'b1) begin errors++; $display("FAIL relock_24: got %b want 1", lk1); end
        feed_err(7);
        feed_clean(57);
        feed_err(1);
        checks++; if (lk1 !== 1'b1 || ec1 !== 16'd16) begin
            errors++; $display("FAIL window_reset: locked %b count %0d want 1/16", lk1, ec1);
        end
    endtask

    task automatic test_stuck_zero;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0);
            if (lk1 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stuck0_lock: %0d locked cycles want 0", bad); end
        checks++; if (st1 !== ST_HUNT || ec1 !== 16'd0) begin
            errors++; $display("FAIL stuck0_state: state %0d count %0d want 1/0", st1, ec1);
        end
    endtask

    task automatic test_valid_toggle;
        int          bad = 0;
        int          vcnt = 0;
        logic        v, b;
        logic        exp_lk;
        logic [1:0]  exp_st;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) gen(b);
            else b = 1'($urandom_range(0, 1));
            step(v, b);
            if (v) vcnt++;
            exp_lk = (vcnt >= 24);
            exp_st = (vcnt < 8) ? ST_SEED : ((vcnt < 24) ? ST_HUNT : ST_LOCKED);
            if (lk1 !== exp_lk || st1 !== exp_st || ep1 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL valid_toggle: %0d bad cycles want 0", bad); end
        checks++; if (ec1 !== 16'd0 || lk1 !== (vcnt >= 24)) begin
            errors++; $display("FAIL valid_toggle_end: count %0d locked %b (valid %0d) want 0/locked", ec1, lk1, vcnt);
        end
    endtask

    task automatic test_saturate;
        logic b;
        do_reset();
        feed_clean(24);
        checks++; if (lk2 !== 1'b1) begin errors++; $display("FAIL sat_lock: got %b want 1", lk2); end
        feed_err(14);
        checks++; if (ec2 !== 4'd14 || ep2 !== 1'b1) begin
            errors++; $display("FAIL sat_14: count %0d pulse %b want 14/1", ec2, ep2);
        end
        feed_err(1);
        checks++; if (ec2 !== 4'd15) begin errors++; $display("FAIL sat_15: got %0d want 15", ec2); end
        feed_err(5);
        checks++; if (ec2 !== 4'd15 || lk2 !== 1'b1) begin
            errors++; $display("FAIL sat_hold: count %0d locked %b want 15/1", ec2, lk2);
        end
        clr = 1'b1;
        feed_err(1);
        checks++; if (ec2 !== 4'd0 || ep2 !== 1'b1) begin
            errors++; $display("FAIL clr_collide: count %0d pulse %b want 0/1", ec2, ep2);
        end
        clr = 1'b0;
        feed_err(1);
        checks++; if (ec2 !== 4'd1) begin errors++; $display("FAIL after_clr: got %0d want 1", ec2); end
        clr = 1'b1;
        gen(b);
        step(1'b1, b);
        clr = 1'b0;
        checks++; if (ec2 !== 4'd0 || ep2 !== 1'b0 || lk2 !== 1'b1) begin
            errors++; $display("FAIL clr_clean: count %0d pulse %b locked %b want 0/0/1", ec2, ep2, lk2);
        end
        feed_err(1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (lk2 !== 1'b0 || ep2 !== 1'b0 || ec2 !== 4'd0 || st2 !== ST_SEED) begin
            errors++; $display("FAIL async_rst2: locked %b pulse %b count %0d state %0d want all 0", lk2, ep2, ec2, st2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_async_reset();
        test_lol_relock();
        test_stuck_zero();
        test_valid_toggle();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
